fifo_stream_reader: RTL and testbench
=====================================

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of the FIFO read data and the output data.
REQ-002 Parameter CNT_WIDTH, default 8: width of the burst length and the internal counters.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  single clock; all state SHALL be updated on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-007 len  input  CNT_WIDTH  number of FIFO entries to read in the burst; sampled with start.
REQ-008 fifo_rden  output  1  read strobe to the FIFO read port.
REQ-009 fifo_data  input  DATA_WIDTH  FIFO read data, valid on the cycle after fifo_rden is high.
REQ-010 fifo_empty  input  1  FIFO empty flag; no read SHALL be issued while it is high.
REQ-011 out_data  output  DATA_WIDTH  downstream data word.
REQ-012 out_valid  output  1  out_data holds a valid word.
REQ-013 out_ready  input  1  downstream accepts the word.
REQ-014 busy  output  1  a burst is in progress (READ or DRAIN).
REQ-015 done  output  1  one-cycle pulse when a burst completes.

Function
REQ-016 The FSM SHALL have four states: IDLE, READ, DRAIN, DONE.
REQ-017 IDLE with start=1 and len>0: latch len, clear the issued and delivered counters, go to READ.
REQ-018 IDLE with start=1 and len=0: go to DONE without issuing any read.
REQ-019 start SHALL be ignored in every state other than IDLE.
REQ-020 READ: fifo_rden=1 when fifo_empty=0, issued<len, and (buffer occupancy + reads in flight) < 2.
REQ-021 fifo_rden SHALL be a combinational function of the state and registers plus fifo_empty, and SHALL never be high outside READ.
REQ-022 Each issued read SHALL capture fifo_data into a 2-entry output buffer exactly one cycle after the fifo_rden cycle.
REQ-023 The issued counter SHALL increment on every fifo_rden cycle; READ -> DRAIN when issued reaches len.
REQ-024 out_valid SHALL equal (buffer occupancy > 0); out_data SHALL be the oldest buffered word.
REQ-025 A transfer occurs on a cycle with out_valid=1 and out_ready=1; delivered SHALL increment and the buffer SHALL pop.
REQ-026 Once out_valid is high, out_valid and out_data SHALL stay stable until the transfer.
REQ-027 A simultaneous capture and pop in one cycle SHALL leave the occupancy unchanged and SHALL preserve word order.
REQ-028 Words SHALL reach the output in FIFO order, with no loss or duplication.
REQ-029 DRAIN -> DONE when delivered reaches len, with the buffer empty and no read in flight.
REQ-030 DONE: done=1 for exactly one cycle, then go to IDLE.
REQ-031 busy SHALL be 1 in READ and DRAIN, and 0 in IDLE and DONE.
REQ-032 With out_ready held at 1 and the FIFO non-empty, the block SHALL sustain one word per cycle.
REQ-033 Latency from the first fifo_rden to the first out_valid SHALL be 2 cycles (1 cycle FIFO read + 1 cycle capture).
REQ-034 The counters are CNT_WIDTH bits wide; len=2^CNT_WIDTH-1 SHALL complete without wrap-around.
REQ-035 fifo_empty rising in the middle of a burst SHALL stall further reads only; reads SHALL resume when it falls.

Reset
REQ-036 While rst=1: state=IDLE, fifo_rden=0, out_valid=0, out_data=0, busy=0, done=0, counters=0, buffer cleared.
REQ-037 Reset in the middle of a burst SHALL abort it; any read in flight SHALL be discarded and no done pulse SHALL be generated.
REQ-038 After rst falls, the block SHALL accept start on the first clock edge.

Verification
REQ-039 Basic burst: FIFO preloaded with 0x11,0x22,0x33; start with len=3; out_ready=1 -> out_data 0x11,0x22,0x33 on consecutive cycles, first out_valid 2 cycles after the first fifo_rden, then one done pulse.
REQ-040 Backpressure: len=4; out_ready=0 for 5 cycles, then 1 -> at most 2 fifo_rden cycles before the first transfer; out_data stays 0x11 while stalled; all 4 words delivered in order.
REQ-041 Empty stall: FIFO holds 1 word and len=2; push 0x44 ten cycles later -> fifo_rden stays 0 while fifo_empty=1; output is 0x11 then 0x44; done after the second transfer.
REQ-042 Zero length: start with len=0 -> no fifo_rden, done high in the cycle after start, busy never high.
REQ-043 Reset in the middle of a burst: assert rst 1 cycle after the second fifo_rden of a len=5 burst -> all outputs 0 at once, no done; a new len=1 burst then completes normally.
REQ-044 Start while busy: pulse start with len=9 during a len=3 burst -> ignored; exactly 3 reads and a single done pulse.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Burst reader: pulls a programmed number of words from a FIFO read port and
// streams them downstream through a 2-entry valid/ready output buffer.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  len,
    output logic                  fifo_rden,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t state;
    state_t state_nxt;

    logic [CNT_WIDTH-1:0]  len_q;
    logic [CNT_WIDTH-1:0]  issued;
    logic [CNT_WIDTH-1:0]  delivered;
    logic                  in_flight;
    logic [1:0]            occ;
    logic [DATA_WIDTH-1:0] slot0;
    logic [DATA_WIDTH-1:0] slot1;

    logic                  pop;
    logic                  capture;
    logic                  burst_start;
    logic [1:0]            credits;

    assign out_valid = (occ != 2'd0);
    assign out_data  = slot0;
    assign pop       = out_valid && out_ready;
    assign capture   = in_flight;

    // Slots still claimed at the next edge: buffered words plus the read in
    // flight, minus the word leaving this cycle, so a transfer frees its slot
    // for a new read in the same cycle and one word per cycle is sustained.
    assign credits = occ + {1'b0, in_flight} - {1'b0, pop};

    // NOTE: every output of this block gets a default before the case, so no
    // path through it can leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        burst_start = 1'b0;
        fifo_rden   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        burst_start = 1'b1;
                        state_nxt   = S_READ;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end

            S_READ: begin
                busy      = 1'b1;
                fifo_rden = !fifo_empty && (issued < len_q) && (credits < 2'd2);
                if (fifo_rden && (issued == len_q - CNT_ONE)) begin
                    state_nxt = S_DRAIN;
                end
            end

            S_DRAIN: begin
                busy = 1'b1;
                if ((delivered == len_q) && (occ == 2'd0) && !in_flight) begin
                    state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the edge, independent of process order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q     <= '0;
            issued    <= '0;
            delivered <= '0;
        end else if (burst_start) begin
            len_q     <= len;
            issued    <= '0;
            delivered <= '0;
        end else begin
            if (fifo_rden) begin
                issued <= issued + CNT_ONE;
            end
            if (pop) begin
                delivered <= delivered + CNT_ONE;
            end
        end
    end

    // Clearing in_flight on reset drops any word the FIFO is still returning.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_flight <= 1'b0;
        end else begin
            in_flight <= fifo_rden;
        end
    end

    // NOTE: the two buffer slots are reset like ordinary registers because the
    // head slot drives out_data, which must read zero while reset is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ   <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            unique case ({capture, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        slot0 <= fifo_data;
                    end else begin
                        slot1 <= fifo_data;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    occ   <= occ - 2'd1;
                end
                2'b11: begin
                    // Head leaves as the new word arrives; occupancy is unchanged.
                    if (occ == 2'd1) begin
                        slot0 <= fifo_data;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= fifo_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a small FIFO model feeds the reader
// and a negedge monitor records reads, transfers and done pulses.
module tb_fifo_stream_reader;

    localparam int DW = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] len;
    logic          fifo_rden;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_empty;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    fifo_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .fifo_rden  (fifo_rden),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    // FIFO model: data appears on the cycle after the read strobe.
    logic [DW-1:0] mem [0:1023];
    logic [9:0]    rd_ptr = '0;
    logic [9:0]    wr_ptr = '0;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_rden) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 10'd1;
        end
    end

    // Monitor
    int            cyc          = 0;
    int            rden_total   = 0;
    int            bad_rd_total = 0;
    int            done_total   = 0;
    int            busy_total   = 0;
    int            stab_err     = 0;
    int            done_cyc     = 0;
    logic          prev_valid   = 1'b0;
    logic          prev_ready   = 1'b0;
    logic [DW-1:0] prev_data    = '0;
    logic [DW-1:0] got_q [$];
    int            xfer_cyc [$];
    int            rden_cyc [$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rden) begin
            rden_total <= rden_total + 1;
            rden_cyc.push_back(cyc);
            if (fifo_empty) bad_rd_total <= bad_rd_total + 1;
        end
        if (done) begin
            done_total <= done_total + 1;
            done_cyc   <= cyc;
        end
        if (busy) busy_total <= busy_total + 1;
        if (!rst && prev_valid && !prev_ready && (!out_valid || out_data != prev_data))
            stab_err <= stab_err + 1;
        if (out_valid && out_ready) begin
            got_q.push_back(out_data);
            xfer_cyc.push_back(cyc);
        end
        prev_valid <= out_valid && !rst;
        prev_ready <= out_ready;
        prev_data  <= out_data;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] got_at(input int idx);
        if (idx < got_q.size()) return {24'd0, got_q[idx]};
        return 32'hDEAD;
    endfunction

    function automatic int xfer_at(input int idx);
        if (idx < xfer_cyc.size()) return xfer_cyc[idx];
        return -1000;
    endfunction

    function automatic int rden_at(input int idx);
        if (idx < rden_cyc.size()) return rden_cyc[idx];
        return -1000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        mem[wr_ptr] = d;
        wr_ptr      = wr_ptr + 10'd1;
    endtask

    task automatic flush();
        wr_ptr = rd_ptr;
    endtask

    task automatic pulse_start(input logic [CW-1:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base, input int budget);
        int n = 0;
        while (done_total == base && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, (done_total != base) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        int rb, xb, db, bb, eb, gb, errs;

        rst = 1'b1; start = 1'b0; len = '0; out_ready = 1'b0;
        tick(); tick();
        check("rst_rden",      {31'd0, fifo_rden}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data",  {24'd0, out_data},  32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_done",      {31'd0, done},      32'd0);
        rst = 1'b0;
        tick();

        // Basic burst of three words at full rate
        push(8'h11); push(8'h22); push(8'h33);
        out_ready = 1'b1;
        rb = rden_cyc.size(); gb = got_q.size(); db = done_total;
        pulse_start(8'd3);
        wait_done("t1", db, 40);
        repeat (4) tick();
        check("t1_w0", got_at(gb),     32'h11);
        check("t1_w1", got_at(gb + 1), 32'h22);
        check("t1_w2", got_at(gb + 2), 32'h33);
        check("t1_count", got_q.size() - gb, 32'd3);
        check("t1_latency", xfer_at(gb) - rden_at(rb), 32'd2);
        check("t1_back2back_a", xfer_at(gb + 1) - xfer_at(gb), 32'd1);
        check("t1_back2back_b", xfer_at(gb + 2) - xfer_at(gb + 1), 32'd1);
        check("t1_reads", rden_cyc.size() - rb, 32'd3);
        check("t1_done_pulses", done_total - db, 32'd1);

        // Backpressure: downstream stalls right after start
        flush();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        out_ready = 1'b0;
        rb = rden_total; gb = got_q.size(); db = done_total; eb = stab_err;
        pulse_start(8'd4);
        repeat (5) tick();
        check("t2_reads_stalled", rden_total - rb, 32'd2);
        check("t2_valid_stalled", {31'd0, out_valid}, 32'd1);
        check("t2_data_stalled",  {24'd0, out_data},  32'h11);
        out_ready = 1'b1;
        wait_done("t2", db, 40);
        repeat (3) tick();
        check("t2_w0", got_at(gb),     32'h11);
        check("t2_w1", got_at(gb + 1), 32'h22);
        check("t2_w2", got_at(gb + 2), 32'h33);
        check("t2_w3", got_at(gb + 3), 32'h44);
        check("t2_count", got_q.size() - gb, 32'd4);
        check("t2_stable", stab_err - eb, 32'd0);
        check("t2_done_pulses", done_total - db, 32'd1);

        // Empty stall: second word arrives ten cycles late
        flush();
        push(8'h11);
        rb = rden_total; gb = got_q.size(); db = done_total; eb = bad_rd_total;
        pulse_start(8'd2);
        repeat (10) tick();
        check("t3_reads_while_empty", rden_total - rb, 32'd1);
        check("t3_busy_stalled", {31'd0, busy}, 32'd1);
        check("t3_valid_stalled", {31'd0, out_valid}, 32'd0);
        push(8'h44);
        wait_done("t3", db, 40);
        repeat (3) tick();
        check("t3_w0", got_at(gb),     32'h11);
        check("t3_w1", got_at(gb + 1), 32'h44);
        check("t3_reads", rden_total - rb, 32'd2);
        check("t3_rd_on_empty", bad_rd_total - eb, 32'd0);
        check("t3_done_after_xfer", (done_cyc > xfer_at(gb + 1)) ? 32'd1 : 32'd0, 32'd1);
        check("t3_done_pulses", done_total - db, 32'd1);

        // Zero length
        rb = rden_total; db = done_total; bb = busy_total;
        pulse_start(8'd0);
        check("t4_done_next_cycle", {31'd0, done}, 32'd1);
        check("t4_busy", {31'd0, busy}, 32'd0);
        repeat (4) tick();
        check("t4_reads", rden_total - rb, 32'd0);
        check("t4_done_pulses", done_total - db, 32'd1);
        check("t4_busy_cycles", busy_total - bb, 32'd0);

        // Reset one cycle after the second read of a five-word burst
        flush();
        for (int i = 0; i < 5; i++) push(8'hA1 + 8'(i));
        rb = rden_total; db = done_total;
        pulse_start(8'd5);
        begin
            int n = 0;
            while (rden_total - rb < 2 && n < 20) begin
                tick();
                n++;
            end
        end
        check("t5_two_reads", rden_total - rb, 32'd2);
        rst = 1'b1;
        #1;
        check("t5_rst_rden",      {31'd0, fifo_rden}, 32'd0);
        check("t5_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("t5_rst_out_data",  {24'd0, out_data},  32'd0);
        check("t5_rst_busy",      {31'd0, busy},      32'd0);
        check("t5_rst_done",      {31'd0, done},      32'd0);
        repeat (3) tick();
        check("t5_no_done", done_total - db, 32'd0);
        flush();
        push(8'h5A);
        gb = got_q.size(); db = done_total;
        rst   = 1'b0;
        start = 1'b1;
        len   = 8'd1;
        tick();
        start = 1'b0;
        check("t5_restart_busy", {31'd0, busy}, 32'd1);
        wait_done("t5", db, 20);
        repeat (3) tick();
        check("t5_w0", got_at(gb), 32'h5A);
        check("t5_count", got_q.size() - gb, 32'd1);
        check("t5_done_pulses", done_total - db, 32'd1);

        // Start while busy is ignored
        flush();
        push(8'h61); push(8'h62); push(8'h63);
        for (int i = 0; i < 8; i++) push(8'hE0 + 8'(i));
        rb = rden_total; gb = got_q.size(); db = done_total;
        pulse_start(8'd3);
        tick();
        pulse_start(8'd9);
        wait_done("t6", db, 40);
        repeat (10) tick();
        check("t6_reads", rden_total - rb, 32'd3);
        check("t6_count", got_q.size() - gb, 32'd3);
        check("t6_w2", got_at(gb + 2), 32'h63);
        check("t6_done_pulses", done_total - db, 32'd1);
        check("t6_idle_busy", {31'd0, busy}, 32'd0);

        // Maximum length with sustained throughput
        flush();
        for (int i = 0; i < 255; i++) push(8'((i * 7 + 3) & 255));
        rb = rden_total; gb = got_q.size(); db = done_total;
        pulse_start(8'd255);
        wait_done("t7", db, 600);
        repeat (3) tick();
        errs = 0;
        for (int i = 0; i < 255; i++)
            if (got_at(gb + i) != 32'((i * 7 + 3) & 255)) errs++;
        check("t7_order_errors", errs, 32'd0);
        check("t7_count", got_q.size() - gb, 32'd255);
        check("t7_reads", rden_total - rb, 32'd255);
        check("t7_span", xfer_at(gb + 254) - xfer_at(gb), 32'd254);
        check("t7_done_pulses", done_total - db, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
